// File: rtl/seq_div.sv
// Sequential N-bit unsigned restoring divider: one quotient bit per clock, start/busy/done handshake.
// Define SEQ_DIV_DBG_EN to expose the live partial remainder and FSM state as debug ports.
module seq_div #(
  parameter int N = 256
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero
`ifdef SEQ_DIV_DBG_EN
  ,
  output logic [N:0]   dbg_rem,
  output logic [1:0]   dbg_state
`endif
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   q_q, q_d;
  logic [N-1:0]   dvs_q, dvs_d;
  logic [N-1:0]   p_q, p_d;
  logic [N-1:0]   quo_q, quo_d;
  logic [N-1:0]   rem_q, rem_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           dbz_q, dbz_d;
  logic [N:0]     t_s;
  logic           ge_s;

  // Next-state and datapath: accept in IDLE/DONE, one shift/subtract step per RUN cycle
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    dvs_d   = dvs_q;
    p_d     = p_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;
    t_s     = {p_q, q_q[N-1]};
    ge_s    = (t_s >= {1'b0, dvs_q});

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          if (divisor == '0) begin
            quo_d   = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            q_d     = dividend;
            dvs_d   = divisor;
            p_d     = '0;
            cnt_d   = CW'(N - 1);
            dbz_d   = 1'b0;
            state_d = RUN;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // The partial remainder stays below the divisor, so N bits hold T-D exactly
        q_d   = {q_q[N-2:0], ge_s};
        p_d   = ge_s ? N'(t_s - {1'b0, dvs_q}) : t_s[N-1:0];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          quo_d   = q_d;
          rem_d   = p_d;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == RUN);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      q_q     <= '0;
      dvs_q   <= '0;
      p_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      dvs_q   <= dvs_d;
      p_q     <= p_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;

`ifdef SEQ_DIV_DBG_EN
  assign dbg_rem   = {1'b0, p_q};
  assign dbg_state = state_q;
`endif

endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div: directed cases plus random operands against an arithmetic model.
module tb_seq_div;
  localparam int N = 256;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_by_zero;
`ifdef SEQ_DIV_DBG_EN
  logic [N:0]   dbg_rem;
  logic [1:0]   dbg_state;
`endif

  int compared   = 0;
  int mismatched = 0;

  seq_div #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .quotient   (quotient),
    .remainder  (remainder),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero)
`ifdef SEQ_DIV_DBG_EN
    ,
    .dbg_rem    (dbg_rem),
    .dbg_state  (dbg_state)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [N:0] obs, input logic [N:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] rand_wide();
    logic [N-1:0] r;
    for (int k = 0; k < N / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // Issue one operation from IDLE/DONE and check result, latency and busy length.
  // Returns sampled just after the done edge, so a following call is back-to-back.
  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input string tag);
    logic [N-1:0] eq, er;
    logic         ez;
    int           exp_lat, lat, bcnt;
    bit           seen;
    if (b == '0) begin
      eq = '1; er = a; ez = 1'b1; exp_lat = 0;
    end else begin
      eq = a / b; er = a % b; ez = 1'b0; exp_lat = N;
    end
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    step();
    start = 1'b0;
    lat = 0; bcnt = 0; seen = 1'b0;
    for (int i = 0; i < N + 8; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) bcnt++;
      step();
      lat++;
    end
    chk({tag, ".done_seen"}, (N+1)'(seen), (N+1)'(1));
    if (seen) begin
      chk({tag, ".latency"}, (N+1)'(lat), (N+1)'(exp_lat));
      chk({tag, ".busy_cycles"}, (N+1)'(bcnt), (N+1)'(exp_lat));
      chk({tag, ".busy_at_done"}, (N+1)'(busy), (N+1)'(0));
      chk({tag, ".quotient"}, {1'b0, quotient}, {1'b0, eq});
      chk({tag, ".remainder"}, {1'b0, remainder}, {1'b0, er});
      chk({tag, ".div_by_zero"}, (N+1)'(div_by_zero), (N+1)'(ez));
    end
  endtask

  initial begin
    logic [N-1:0] ones, x, a, b;
    int           lat;
    bit           seen;
    ones = '1;
    x    = {16'hDEAD, {14{16'h5A5A}}, 16'hBEEF};

    // Reset, with start asserted to show reset wins
    rst_n = 1'b0; start = 1'b1; dividend = N'(60); divisor = N'(12);
    step();
    step();
    start = 1'b0;
    chk("reset.busy", (N+1)'(busy), (N+1)'(0));
    chk("reset.done", (N+1)'(done), (N+1)'(0));
    chk("reset.dbz", (N+1)'(div_by_zero), (N+1)'(0));
    chk("reset.quotient", {1'b0, quotient}, '0);
    chk("reset.remainder", {1'b0, remainder}, '0);
    rst_n = 1'b1;
    step();

    // 1: basic exact division, then done must be a single-cycle pulse
    do_op(N'(60), N'(12), "t1");
    step();
    chk("t1.done_pulse", (N+1)'(done), (N+1)'(0));
    chk("t1.held_q", {1'b0, quotient}, (N+1)'(5));

    // 2: back-to-back from DONE
    do_op(N'(61), N'(12), "t2a");
    do_op(ones, N'(2), "t2b");
    step();

    // 3: dividend smaller than divisor; equal all-ones operands
    do_op(N'(3), N'(4), "t3a");
    step();
    do_op(ones, ones, "t3b");
    step();

    // 4: divide by zero, then next start clears the flag
    do_op(x, '0, "t4a");
    do_op(N'(8), N'(2), "t4b");
    step();

    // 5: start pulsed during RUN with new operands is ignored
    dividend = N'(100); divisor = N'(7); start = 1'b1;
    step();
    start = 1'b0;
    repeat (49) step();
    dividend = N'(9); divisor = N'(3); start = 1'b1;
    step();
    start = 1'b0; dividend = rand_wide(); divisor = rand_wide();
    lat = 50; seen = 1'b0;
    for (int i = 0; i < N + 8; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      step();
      lat++;
    end
    chk("t5.done_seen", (N+1)'(seen), (N+1)'(1));
    chk("t5.latency", (N+1)'(lat), (N+1)'(N));
    chk("t5.quotient", {1'b0, quotient}, (N+1)'(14));
    chk("t5.remainder", {1'b0, remainder}, (N+1)'(2));
    step();

    // 6: reset mid-RUN aborts with no done pulse
    dividend = N'(5); divisor = N'(1); start = 1'b1;
    step();
    start = 1'b0;
    repeat (99) step();
    rst_n = 1'b0;
    step();
    chk("t6.busy", (N+1)'(busy), (N+1)'(0));
    chk("t6.quotient", {1'b0, quotient}, '0);
    chk("t6.remainder", {1'b0, remainder}, '0);
    step();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < N + 8; i++) begin
      if (done || busy) seen = 1'b1;
      step();
    end
    chk("t6.no_done_after_abort", (N+1)'(seen), (N+1)'(0));
    do_op(N'(5), N'(1), "t6r");
    step();

    // Random operands: mixed magnitudes, occasional zero or equal divisor
    for (int it = 0; it < 14; it++) begin
      a = rand_wide() >> $urandom_range(0, N - 1);
      b = rand_wide() >> $urandom_range(0, N - 1);
      case ($urandom_range(0, 5))
        0:       b = '0;
        1:       b = a;
        default: b = b;
      endcase
      do_op(a, b, $sformatf("rnd%0d", it));
      if ($urandom_range(0, 1) == 0) step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
